relu_col_scheduler: RTL and testbench

//  Shares one reLU unit among N_COLS weight-stationary array columns. Round-robin picks a

---
 rtl/relu_sched_pkg.sv | 36 +++
 rtl/rr_arbiter.sv | 46 ++++
 rtl/relu_col_scheduler.sv | 156 +++++++++++++++
 tb/tb_relu_col_scheduler.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/relu_sched_pkg.sv
// Shared types and the requantization helper for the column reLU scheduler.
// sat_requant is sized by the package widths; the top's width parameters must match them.
package relu_sched_pkg;

    localparam int unsigned AccWidth  = 24;
    localparam int unsigned DataWidth = 8;
    localparam int unsigned ShiftW    = 5;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    localparam logic signed [AccWidth:0] SatMax = (AccWidth+1)'((2 ** (DataWidth - 1)) - 1);
    localparam logic signed [AccWidth:0] SatMin = (AccWidth+1)'(-(2 ** (DataWidth - 1)));

    // Round half up, arithmetic shift in AccWidth+1 bits, then clamp to the activation range.
    function automatic logic signed [DataWidth-1:0] sat_requant(
        input logic signed [AccWidth-1:0] acc,
        input logic        [ShiftW-1:0]   shift
    );
        logic signed [AccWidth:0] ext;
        logic signed [AccWidth:0] rnd;
        logic signed [AccWidth:0] t;
        ext = {acc[AccWidth-1], acc};
        rnd = '0;
        if (shift != '0) begin
            rnd = (AccWidth+1)'(1) << (shift - ShiftW'(1));
        end
        t = (ext + rnd) >>> shift;
        if (t > SatMax) begin
            return SatMax[DataWidth-1:0];
        end else if (t < SatMin) begin
            return SatMin[DataWidth-1:0];
        end
        return t[DataWidth-1:0];
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request at or after the pointer.
// The pointer moves just past the winner whenever a grant is issued.
module rr_arbiter #(
    parameter  int unsigned N    = 4,
    localparam int unsigned IdxW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req_i,
    input  logic            en_i,
    output logic [N-1:0]    gnt_o,
    output logic [IdxW-1:0] idx_o
);

    logic [IdxW-1:0] ptr_q, ptr_d;
    logic [IdxW-1:0] cand;
    logic            found;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = '0;
        if (en_i) begin
            for (int i = 0; i < N; i++) begin
                // N is a power of two, so the index wraps naturally
                cand = ptr_q + IdxW'(i);
                if (!found && req_i[cand]) begin
                    found       = 1'b1;
                    gnt_o[cand] = 1'b1;
                    idx_o       = cand;
                end
            end
        end
        ptr_d = found ? idx_o + IdxW'(1) : ptr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/relu_col_scheduler.sv
// Shares one 1-cycle reLU unit among N_COLS columns: round-robin grant, requant, issue,
// and a 2-entry result FIFO, sequenced per tile by a start/done FSM.
module relu_col_scheduler
    import relu_sched_pkg::*;
#(
    parameter  int unsigned N_COLS     = 4,
    parameter  int unsigned ACC_WIDTH  = AccWidth,
    parameter  int unsigned DATA_WIDTH = DataWidth,
    parameter  int unsigned SHIFT_W    = ShiftW,
    parameter  int unsigned CNT_W      = 16,
    localparam int unsigned IdxW       = $clog2(N_COLS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [SHIFT_W-1:0]          cfg_shift,
    input  logic                        cfg_relu,
    input  logic [CNT_W-1:0]            cfg_count,
    input  logic [N_COLS-1:0]           col_valid,
    input  logic [N_COLS*ACC_WIDTH-1:0] col_acc,
    output logic [N_COLS-1:0]           col_ready,
    output logic                        relu_iv,
    output logic [DATA_WIDTH-1:0]       relu_in,
    input  logic                        relu_ov,
    input  logic [DATA_WIDTH-1:0]       relu_od,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_WIDTH-1:0]       out_data,
    output logic [IdxW-1:0]             out_col,
    output logic                        busy,
    output logic                        done
);

    state_e state_q, state_d;

    logic [SHIFT_W-1:0]    shift_q;
    logic                  relu_q;
    logic [CNT_W-1:0]      count_q, issued_q;

    logic                  iv_q, pv_q;
    logic [DATA_WIDTH-1:0] in_q, pd_q;
    logic [IdxW-1:0]       icol_q, pcol_q;

    logic [DATA_WIDTH-1:0] fd_q [2];
    logic [IdxW-1:0]       fc_q [2];
    logic                  wp_q, rp_q;
    logic [1:0]            occ_q;

    logic [2:0]            pending;
    logic                  grant_en, hs, wr, rd;
    logic [IdxW-1:0]       win;
    logic [ACC_WIDTH-1:0]  acc_sel;
    logic [DATA_WIDTH-1:0] wdata;

    // Everything granted but not yet popped counts against the two FIFO slots.
    assign pending  = {1'b0, occ_q} + {2'b0, iv_q} + {2'b0, pv_q};
    assign grant_en = (state_q == RUN) && (issued_q < count_q) && (pending < 3'd2);

    rr_arbiter #(
        .N (N_COLS)
    ) u_arb (
        .clk   (clk),
        .rst   (rst),
        .req_i (col_valid),
        .en_i  (grant_en),
        .gnt_o (col_ready),
        .idx_o (win)
    );

    assign hs      = |col_ready;
    assign acc_sel = col_acc[int'(win)*ACC_WIDTH +: ACC_WIDTH];
    assign wr      = pv_q && relu_ov;
    assign wdata   = relu_q ? relu_od : pd_q;
    assign rd      = out_valid && out_ready;

    assign relu_iv   = iv_q;
    assign relu_in   = in_q;
    assign out_valid = (occ_q != 2'd0);
    assign out_data  = out_valid ? fd_q[rp_q] : '0;
    assign out_col   = out_valid ? fc_q[rp_q] : '0;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = (cfg_count == '0) ? DONE : RUN;
            RUN:     if (issued_q == count_q) state_d = DRAIN;
            DRAIN:   if (!iv_q && !pv_q && occ_q == 2'd0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            relu_q   <= 1'b0;
            count_q  <= '0;
            issued_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && start) begin
                shift_q  <= cfg_shift;
                relu_q   <= cfg_relu;
                count_q  <= cfg_count;
                issued_q <= '0;
            end else if (hs) begin
                issued_q <= issued_q + CNT_W'(1);
            end
        end
    end

    // Issue stage, then the stage aligned with the reLU unit's result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iv_q   <= 1'b0;
            in_q   <= '0;
            icol_q <= '0;
            pv_q   <= 1'b0;
            pd_q   <= '0;
            pcol_q <= '0;
        end else begin
            iv_q   <= hs;
            in_q   <= hs ? sat_requant(acc_sel, shift_q) : '0;
            icol_q <= win;
            pv_q   <= iv_q;
            pd_q   <= in_q;
            pcol_q <= icol_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                fd_q[i] <= '0;
                fc_q[i] <= '0;
            end
            wp_q  <= 1'b0;
            rp_q  <= 1'b0;
            occ_q <= 2'd0;
        end else begin
            if (wr) begin
                fd_q[wp_q] <= wdata;
                fc_q[wp_q] <= pcol_q;
                wp_q       <= ~wp_q;
            end
            if (rd) begin
                rp_q <= ~rp_q;
            end
            occ_q <= occ_q + {1'b0, wr} - {1'b0, rd};
        end
    end

endmodule

// File: tb/tb_relu_col_scheduler.sv
// Self-checking bench for relu_col_scheduler: directed steps plus randomized tiles,
// checked against a behavioural model of grants, requant/reLU and in-order delivery.
module tb_relu_col_scheduler;

    localparam int N  = 4;
    localparam int AW = 24;
    localparam int DW = 8;
    localparam int SW = 5;
    localparam int CW = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [SW-1:0]   cfg_shift;
    logic            cfg_relu;
    logic [CW-1:0]   cfg_count;
    logic [N-1:0]    col_valid;
    logic [N*AW-1:0] col_acc;
    logic [N-1:0]    col_ready;
    logic            relu_iv;
    logic [DW-1:0]   relu_in;
    logic            relu_ov;
    logic [DW-1:0]   relu_od;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_data;
    logic [1:0]      out_col;
    logic            busy;
    logic            done;

    relu_col_scheduler dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cfg_shift (cfg_shift),
        .cfg_relu  (cfg_relu),
        .cfg_count (cfg_count),
        .col_valid (col_valid),
        .col_acc   (col_acc),
        .col_ready (col_ready),
        .relu_iv   (relu_iv),
        .relu_in   (relu_in),
        .relu_ov   (relu_ov),
        .relu_od   (relu_od),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_col   (out_col),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // External reLU unit: one-cycle latency
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            relu_ov <= 1'b0;
            relu_od <= '0;
        end else begin
            relu_ov <= relu_iv;
            relu_od <= (relu_iv && !relu_in[DW-1]) ? relu_in : '0;
        end
    end

    int checks = 0;
    int errors = 0;

    int  ptr_m, issued_m, cnt_m, outst_m, shift_m;
    bit  relu_m, tile_on;
    int  exp_data_q[$];
    int  exp_col_q[$];
    int  grant_log[$];
    int  grant_cnt = 0, out_cnt = 0, done_cnt = 0, last_out = 0;

    logic [N-1:0]          expg;
    int                    w, c, ed, ec;
    bit                    can;
    logic signed [AW-1:0]  acc_s;

    function automatic int ref_act(longint acc, int s, bit relu);
        longint t;
        t = (s == 0) ? acc : ((acc + (64'sd1 <<< (s - 1))) >>> s);
        if (t > 127) t = 127;
        if (t < -128) t = -128;
        if (relu && t < 0) t = 0;
        return int'(t);
    endfunction

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Monitor: model grant decision, scoreboard in-order delivery
    always @(negedge clk) begin
        if (!rst) begin
            expg = '0;
            w    = -1;
            can  = tile_on && (issued_m < cnt_m) && (outst_m < 2);
            if (can) begin
                for (int k = 0; k < N; k++) begin
                    c = (ptr_m + k) % N;
                    if (w < 0 && col_valid[c]) w = c;
                end
            end
            if (w >= 0) expg[w] = 1'b1;
            chk("col_ready", col_ready, expg);
            if (w >= 0) begin
                acc_s = col_acc[w*AW +: AW];
                exp_data_q.push_back(ref_act(acc_s, shift_m, relu_m));
                exp_col_q.push_back(w);
                grant_log.push_back(w);
                ptr_m = (w + 1) % N;
                issued_m++;
                outst_m++;
                grant_cnt++;
            end
            if (out_valid && out_ready) begin
                if (exp_data_q.size() == 0) begin
                    chk("out_spurious", out_valid, 0);
                end else begin
                    ed = exp_data_q.pop_front();
                    ec = exp_col_q.pop_front();
                    chk("out_data", $signed(out_data), ed);
                    chk("out_col", out_col, ec);
                    last_out = $signed(out_data);
                    outst_m--;
                    out_cnt++;
                end
            end
            if (done) begin
                done_cnt++;
                chk("done_outstanding", outst_m, 0);
                tile_on = 1'b0;
            end
        end
    end

    task automatic clear_model();
        ptr_m    = 0;
        issued_m = 0;
        cnt_m    = 0;
        outst_m  = 0;
        tile_on  = 1'b0;
        exp_data_q.delete();
        exp_col_q.delete();
    endtask

    task automatic set_acc(input int col, input longint v);
        logic [63:0] tmp;
        tmp = v;
        col_acc[col*AW +: AW] = tmp[AW-1:0];
    endtask

    function automatic longint rand_acc();
        logic signed [AW-1:0] x;
        case ($urandom_range(0, 2))
            0:       return longint'($urandom_range(0, 4095)) - 2048;
            1:       return longint'($urandom_range(0, 80000)) - 40000;
            default: begin
                x = AW'($urandom);
                return x;
            end
        endcase
    endfunction

    task automatic rand_accs();
        for (int i = 0; i < N; i++) set_acc(i, rand_acc());
    endtask

    task automatic start_tile(input int cnt, input int s, input bit r);
        @(posedge clk);
        #1;
        cfg_count = CW'(cnt);
        cfg_shift = SW'(s);
        cfg_relu  = r;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        cnt_m    = cnt;
        shift_m  = s;
        relu_m   = r;
        issued_m = 0;
        tile_on  = (cnt != 0);
    endtask

    task automatic wait_done(input string tag, input int bound);
        int d0, n;
        d0 = done_cnt;
        n  = 0;
        while (done_cnt == d0 && n < bound) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk(tag, done_cnt, d0 + 1);
    endtask

    task automatic directed(input string tag, input longint acc, input int s, input bit r,
                            input int exp);
        col_valid = 4'b0001;
        set_acc(0, acc);
        start_tile(1, s, r);
        wait_done({tag, "_done"}, 50);
        chk(tag, last_out, exp);
    endtask

    int g0, o0, d0, n;

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        cfg_shift = '0;
        cfg_relu  = 1'b0;
        cfg_count = '0;
        col_valid = '0;
        col_acc   = '0;
        out_ready = 1'b1;
        clear_model();
        @(posedge clk);
        #1;
        chk("rst_col_ready", col_ready, 0);
        chk("rst_relu_iv", relu_iv, 0);
        chk("rst_relu_in", relu_in, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_col", out_col, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // All columns valid, 8 outputs: strict round robin
        col_valid = '1;
        rand_accs();
        grant_log.delete();
        o0 = out_cnt;
        start_tile(8, $urandom_range(0, 12), 1'b1);
        wait_done("t1_done", 300);
        chk("t1_grant_count", grant_log.size(), 8);
        for (int i = 0; i < 8 && i < grant_log.size(); i++) chk("t1_grant_order", grant_log[i], i % 4);
        chk("t1_out_count", out_cnt - o0, 8);

        // Requant / reLU / bypass corner values
        directed("relu_pos", 300, 2, 1'b1, 75);
        directed("relu_neg", -300, 2, 1'b1, 0);
        directed("relu_sat", 40000, 0, 1'b1, 127);
        directed("byp_neg", -300, 2, 1'b0, -75);
        directed("byp_half", -6, 2, 1'b0, -1);

        // Backpressure: only two outstanding, then in-order drain
        col_valid = '1;
        rand_accs();
        out_ready = 1'b0;
        g0 = grant_cnt;
        o0 = out_cnt;
        start_tile(6, $urandom_range(0, 12), 1'b0);
        repeat (20) @(posedge clk);
        #1;
        chk("t4_grants_held", grant_cnt - g0, 2);
        chk("t4_col_ready", col_ready, 0);
        chk("t4_out_valid", out_valid, 1);
        out_ready = 1'b1;
        wait_done("t4_done", 200);
        chk("t4_out_count", out_cnt - o0, 6);

        // Single requester
        col_valid = 4'b0100;
        grant_log.delete();
        start_tile(3, 4, 1'b1);
        wait_done("t5_done", 100);
        chk("t5_grant_count", grant_log.size(), 3);
        for (int i = 0; i < grant_log.size(); i++) chk("t5_grant_col", grant_log[i], 2);

        // Randomized tiles
        for (int t = 0; t < 6; t++) begin
            start_tile($urandom_range(1, 20), $urandom_range(0, 12), 1'($urandom));
            d0 = done_cnt;
            n  = 0;
            while (done_cnt == d0 && n < 3000) begin
                @(posedge clk);
                #1;
                col_valid = N'($urandom);
                rand_accs();
                out_ready = ($urandom_range(0, 3) != 0);
                n++;
            end
            chk("rand_done", done_cnt, d0 + 1);
            out_ready = 1'b1;
        end

        // Zero-length tile
        col_valid = '1;
        d0 = done_cnt;
        g0 = grant_cnt;
        start_tile(0, 0, 1'b1);
        chk("t6_done_pulse", done, 1);
        chk("t6_busy", busy, 1);
        @(posedge clk);
        #1;
        chk("t6_done_clear", done, 0);
        chk("t6_idle", busy, 0);
        chk("t6_done_count", done_cnt, d0 + 1);
        chk("t6_no_grants", grant_cnt, g0);

        // Reset mid-tile
        out_ready = 1'b0;
        start_tile(20, 3, 1'b1);
        repeat (4) @(posedge clk);
        #3;
        rst = 1'b1;
        clear_model();
        #1;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_out_valid", out_valid, 0);
        chk("rst_mid_relu_iv", relu_iv, 0);
        chk("rst_mid_col_ready", col_ready, 0);
        repeat (2) @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        d0 = done_cnt;
        repeat (10) @(posedge clk);
        #1;
        chk("rst_mid_no_done", done_cnt, d0);
        chk("rst_mid_idle", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
